// File: rtl/rtype_instr_encoder.sv
// rtl/rtype_instr_encoder.sv - R-type instruction word generator with output FIFO.
// Encodes op/rd/rs1/rs2 into {funct7,rs2,rs1,funct3,rd,opcode} and queues words for issue.
module rtype_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [4:0]       rd_idx,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             illegal_err,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] ISS_ONE  = CNT_W'(1);

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             init_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  opcode;
  logic        legal;
  logic [31:0] word;
  logic        accept, push, pop;

  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    opcode = 7'b0110011;
    legal  = 1'b1;
    case (op)
      4'd0:  funct3 = 3'b000;
      4'd1:  begin funct3 = 3'b000; funct7 = 7'b0100000; end
      4'd2:  funct3 = 3'b001;
      4'd3:  funct3 = 3'b010;
      4'd4:  funct3 = 3'b011;
      4'd5:  funct3 = 3'b100;
      4'd6:  funct3 = 3'b101;
      4'd7:  begin funct3 = 3'b101; funct7 = 7'b0100000; end
      4'd8:  funct3 = 3'b110;
      4'd9:  funct3 = 3'b111;
      4'd10: begin opcode = 7'b0111011; funct3 = 3'b000; end
      4'd11: begin opcode = 7'b0111011; funct3 = 3'b000; funct7 = 7'b0100000; end
      4'd12: begin opcode = 7'b0111011; funct3 = 3'b001; end
      4'd13: begin opcode = 7'b0111011; funct3 = 3'b101; end
      4'd14: begin opcode = 7'b0111011; funct3 = 3'b101; funct7 = 7'b0100000; end
      default: legal = 1'b0;
    endcase
  end

  assign word = {funct7, rs2_idx, rs1_idx, funct3, rd_idx, opcode};

  // Full blocks input even if a pop happens this cycle: no pass-through.
  assign in_ready  = init_q && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign instr     = out_valid ? mem_q[rd_ptr_q] : 32'h0;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    issued_d  = pop  ? issued_q + ISS_ONE : issued_q;
    illegal_d = accept && !legal;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      init_q    <= 1'b0;
      illegal_q <= 1'b0;
      issued_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      init_q    <= 1'b1;
      illegal_q <= illegal_d;
      issued_q  <= issued_d;
    end
  end

  // Storage needs no reset: instr is masked whenever the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign illegal_err = illegal_q;
  assign issued_cnt  = issued_q;

endmodule
